// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel fetch / colour datapath.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int FRAME_W = 8
);
  logic           pixel_en;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           hsync;
  logic           vsync;
  logic           display_en;
  logic           line_start;
  logic           frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output pixel_en, h_cnt, v_cnt, hsync, vsync,
    output display_en, line_start, frame_start, frame_cnt
  );

  modport slave (
    input pixel_en, h_cnt, v_cnt, hsync, vsync,
    input display_en, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    output pixel_en, h_cnt, v_cnt, hsync, vsync,
    output display_en, line_start, frame_start
  );

  modport slave (
    input pixel_en, h_cnt, v_cnt, hsync, vsync,
    input display_en, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Single-clock VGA raster timing generator: clock-enable divider plus h/v counter pair.
// Define VGA_TIMING_FRAME_CNT_EN to add the completed-frame counter (frame_cnt).
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int FRAME_W    = 8
) (
  input  logic              CLK_50,
  input  logic              reset,
  vga_timing_gen_if.master  o_vga
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

  // Elaboration-time guards against mode parameters the counters cannot represent.
  if (CLK_DIV < 1) begin : gBadClkDiv
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : gBadSync
    $error("vga_timing_gen: sync widths must be at least 1");
  end
  if ((2 ** X_W) < H_TOTAL || (2 ** Y_W) < V_TOTAL) begin : gBadWidth
    $error("vga_timing_gen: X_W/Y_W too narrow for the raster totals");
  end
  if (FRAME_W < 1) begin : gBadFrameW
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic [DIV_W-1:0] r_divCnt;
  logic             r_pixelEn;
  logic [X_W-1:0]   r_hCnt;
  logic [Y_W-1:0]   r_vCnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_displayEn;
  logic             r_lineStart;
  logic             r_frameStart;

  logic [DIV_W-1:0] w_divNext;
  logic             w_pixelEnNext;
  logic [X_W-1:0]   w_hNext;
  logic [Y_W-1:0]   w_vNext;
  logic             w_hInSync;
  logic             w_vInSync;
  logic             w_hsyncNext;
  logic             w_vsyncNext;
  logic             w_displayEnNext;
  logic             w_lineStartNext;
  logic             w_frameStartNext;

  // Decodes use the next counter values so every registered output lines up with h_cnt/v_cnt.
  always_comb begin
    w_divNext     = (r_divCnt == DIV_LAST) ? '0 : r_divCnt + DIV_W'(1);
    w_pixelEnNext = (r_divCnt == DIV_LAST);
    w_hNext       = r_hCnt;
    w_vNext       = r_vCnt;

    if (r_pixelEn) begin
      if (r_hCnt == H_LAST) begin
        w_hNext = '0;
        w_vNext = (r_vCnt == V_LAST) ? '0 : r_vCnt + Y_W'(1);
      end else begin
        w_hNext = r_hCnt + X_W'(1);
      end
    end

    w_hInSync        = (32'(w_hNext) >= HS_START) && (32'(w_hNext) < HS_END);
    w_vInSync        = (32'(w_vNext) >= VS_START) && (32'(w_vNext) < VS_END);
    w_hsyncNext      = w_hInSync ? H_SYNC_POL : ~H_SYNC_POL;
    w_vsyncNext      = w_vInSync ? V_SYNC_POL : ~V_SYNC_POL;
    w_displayEnNext  = (32'(w_hNext) < H_ACTIVE) && (32'(w_vNext) < V_ACTIVE);
    w_lineStartNext  = w_pixelEnNext && (w_hNext == '0);
    w_frameStartNext = w_lineStartNext && (w_vNext == '0);
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_divCnt     <= '0;
      r_pixelEn    <= 1'b0;
      r_hCnt       <= '0;
      r_vCnt       <= '0;
      r_hsync      <= ~H_SYNC_POL;
      r_vsync      <= ~V_SYNC_POL;
      r_displayEn  <= 1'b0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_divCnt     <= w_divNext;
      r_pixelEn    <= w_pixelEnNext;
      r_hCnt       <= w_hNext;
      r_vCnt       <= w_vNext;
      r_hsync      <= w_hsyncNext;
      r_vsync      <= w_vsyncNext;
      r_displayEn  <= w_displayEnNext;
      r_lineStart  <= w_lineStartNext;
      r_frameStart <= w_frameStartNext;
    end
  end

  assign o_vga.pixel_en    = r_pixelEn;
  assign o_vga.h_cnt       = r_hCnt;
  assign o_vga.v_cnt       = r_vCnt;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.display_en  = r_displayEn;
  assign o_vga.line_start  = r_lineStart;
  assign o_vga.frame_start = r_frameStart;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] r_frameCnt;

  // Counts on the same edge where both counters return to the origin.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      r_frameCnt <= '0;
    end else if (r_pixelEn && (r_hCnt == H_LAST) && (r_vCnt == V_LAST)) begin
      r_frameCnt <= r_frameCnt + FRAME_W'(1);
    end
  end

  assign o_vga.frame_cnt = r_frameCnt;
`endif

endmodule
